// File: rtl/dbg_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : dbg_frame_packer
// Purpose  : Serialises tag + debug word into SOF/tag/data(MSB first)/checksum
//            byte frames for the write side of the debugger's async FIFO.
// Revision : 1.0
// ============================================================================
module dbg_frame_packer #(
    parameter int         WORD_WIDTH = 32,
    parameter logic [7:0] SOF_BYTE   = 8'hA5
) (
    input  logic                  clk_dst,
    input  logic                  wr_rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [7:0]            in_tag,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic                  fifo_full,
    output logic                  fifo_wr_en,
    output logic [7:0]            fifo_wr_data,
    output logic                  busy,
    output logic [15:0]           frames_sent
);

    localparam int NB = WORD_WIDTH / 8;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SOF  = 3'd1,
        S_TAG  = 3'd2,
        S_DATA = 3'd3,
        S_CHK  = 3'd4
    } state_t;

    state_t                r_state;
    logic [IW-1:0]         r_idx;
    logic [7:0]            r_tag;
    logic [WORD_WIDTH-1:0] r_data;
    logic [15:0]           r_frames;

    logic                  w_accept;
    logic [7:0]            w_sum;
    logic [7:0]            w_chk;
    logic [7:0]            w_data_byte;

    assign in_ready    = (r_state == S_IDLE) || ((r_state == S_CHK) && !fifo_full);
    assign fifo_wr_en  = (r_state != S_IDLE) && !fifo_full;
    assign w_accept    = in_valid && in_ready;
    assign busy        = (r_state != S_IDLE);
    assign frames_sent = r_frames;

    // Checksum is taken from the held word, so a new word captured during the
    // CHK write cannot disturb the byte being emitted.
    always_comb begin
        w_sum       = r_tag;
        w_data_byte = 8'h00;
        for (int i = 0; i < NB; i++) begin
            w_sum = w_sum + r_data[8*i +: 8];
            if (r_idx == IW'(NB - 1 - i)) begin
                w_data_byte = r_data[8*i +: 8];
            end
        end
        w_chk = 8'h00 - w_sum;
    end

    always_comb begin
        fifo_wr_data = 8'h00;
        case (r_state)
            S_SOF:   fifo_wr_data = SOF_BYTE;
            S_TAG:   fifo_wr_data = r_tag;
            S_DATA:  fifo_wr_data = w_data_byte;
            S_CHK:   fifo_wr_data = w_chk;
            default: fifo_wr_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_dst or posedge wr_rst) begin
        if (wr_rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_tag    <= 8'h00;
            r_data   <= '0;
            r_frames <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_tag  <= in_tag;
                r_data <= in_data;
            end
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    r_state <= S_SOF;
                end
            end else if (fifo_wr_en) begin
                case (r_state)
                    S_SOF: r_state <= S_TAG;
                    S_TAG: begin
                        r_state <= S_DATA;
                        r_idx   <= '0;
                    end
                    S_DATA: begin
                        if (r_idx == IW'(NB - 1)) begin
                            r_state <= S_CHK;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                    S_CHK: begin
                        r_frames <= r_frames + 16'd1;
                        r_state  <= w_accept ? S_SOF : S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dbg_frame_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dbg_frame_packer
// Purpose  : Directed self-checking bench for dbg_frame_packer (32- and 8-bit).
// Revision : 1.0
// ============================================================================
module tb_dbg_frame_packer;

    logic        clk_dst = 1'b0;
    logic        wr_rst  = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_tag = 8'h00;
    logic [31:0] in_data = 32'h0;
    logic        fifo_full = 1'b0;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wr_data;
    logic        busy;
    logic [15:0] frames_sent;

    logic        in_valid8 = 1'b0;
    logic        in_ready8;
    logic [7:0]  in_tag8 = 8'h00;
    logic [7:0]  in_data8 = 8'h00;
    logic        fifo_full8 = 1'b0;
    logic        fifo_wr_en8;
    logic [7:0]  fifo_wr_data8;
    logic        busy8;
    logic [15:0] frames_sent8;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_f1 [7]  = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'hEB};
    logic [7:0] exp_b2b[14] = '{8'hA5, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02,
                                8'hA5, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFD};
    logic [7:0] exp_w8 [4]  = '{8'hA5, 8'h10, 8'hF0, 8'h00};

    always #5 clk_dst = ~clk_dst;

    dbg_frame_packer #(.WORD_WIDTH(32), .SOF_BYTE(8'hA5)) u_dut (
        .clk_dst(clk_dst), .wr_rst(wr_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_tag(in_tag), .in_data(in_data),
        .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .busy(busy), .frames_sent(frames_sent)
    );

    dbg_frame_packer #(.WORD_WIDTH(8), .SOF_BYTE(8'hA5)) u_dut8 (
        .clk_dst(clk_dst), .wr_rst(wr_rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_tag(in_tag8), .in_data(in_data8),
        .fifo_full(fifo_full8), .fifo_wr_en(fifo_wr_en8), .fifo_wr_data(fifo_wr_data8),
        .busy(busy8), .frames_sent(frames_sent8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs are driven 1ns after the rising edge; outputs are checked 1ns later.
    task automatic step();
        @(posedge clk_dst);
        #1;
    endtask

    initial begin
        #1;
        check("rst_ready", in_ready, 1);
        check("rst_wr_en", fifo_wr_en, 0);
        check("rst_wr_data", fifo_wr_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_frames", frames_sent, 0);
        step(); step();
        wr_rst = 1'b0;
        step();

        // Single frame
        in_valid = 1'b1; in_tag = 8'h01; in_data = 32'h12345678; #1;
        check("f1_ready", in_ready, 1);
        check("f1_idle_wr", fifo_wr_en, 0);
        step();
        in_valid = 1'b0; #1;
        for (int i = 0; i < 7; i++) begin
            check("f1_wr_en", fifo_wr_en, 1);
            check("f1_byte", fifo_wr_data, exp_f1[i]);
            check("f1_busy", busy, 1);
            step(); #1;
        end
        check("f1_busy_end", busy, 0);
        check("f1_wr_end", fifo_wr_en, 0);
        check("f1_frames", frames_sent, 1);

        // Stall on 0x34 for 5 cycles, then on CHK with a pending word
        in_valid = 1'b1; #1;
        step();
        in_valid = 1'b0; #1;
        for (int i = 0; i < 7; i++) begin
            if (i == 3) begin
                fifo_full = 1'b1; #1;
                for (int k = 0; k < 5; k++) begin
                    check("stall_wr_en", fifo_wr_en, 0);
                    check("stall_data", fifo_wr_data, 8'h34);
                    step(); #1;
                end
                fifo_full = 1'b0; #1;
            end
            if (i == 6) begin
                fifo_full = 1'b1; in_valid = 1'b1; #1;
                for (int k = 0; k < 2; k++) begin
                    check("chkfull_ready", in_ready, 0);
                    check("chkfull_wr_en", fifo_wr_en, 0);
                    check("chkfull_data", fifo_wr_data, 8'hEB);
                    step(); #1;
                end
                fifo_full = 1'b0; in_valid = 1'b0; #1;
            end
            check("stall_wr", fifo_wr_en, 1);
            check("stall_byte", fifo_wr_data, exp_f1[i]);
            step(); #1;
        end
        check("stall_busy_end", busy, 0);
        check("stall_frames", frames_sent, 2);

        // Back-to-back
        in_valid = 1'b1; in_tag = 8'h02; in_data = 32'hFFFFFFFF; #1;
        step();
        in_tag = 8'h03; in_data = 32'h00000000; #1;
        for (int i = 0; i < 14; i++) begin
            if (i == 6) check("b2b_ready_chk", in_ready, 1);
            check("b2b_wr_en", fifo_wr_en, 1);
            check("b2b_byte", fifo_wr_data, exp_b2b[i]);
            step();
            if (i == 6) in_valid = 1'b0;
            #1;
        end
        check("b2b_busy_end", busy, 0);
        check("b2b_frames", frames_sent, 4);

        // Reset mid-frame after the 0x12 byte
        in_valid = 1'b1; in_tag = 8'h01; in_data = 32'h12345678; #1;
        step();
        in_valid = 1'b0; #1;
        for (int i = 0; i < 3; i++) begin
            check("mid_byte", fifo_wr_data, exp_f1[i]);
            step(); #1;
        end
        wr_rst = 1'b1; #1;
        check("mid_rst_wr_en", fifo_wr_en, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_frames", frames_sent, 0);
        check("mid_rst_data", fifo_wr_data, 8'h00);
        step();
        wr_rst = 1'b0; #1;
        in_valid = 1'b1; #1;
        step();
        in_valid = 1'b0; #1;
        for (int i = 0; i < 7; i++) begin
            check("post_rst_wr", fifo_wr_en, 1);
            check("post_rst_byte", fifo_wr_data, exp_f1[i]);
            step(); #1;
        end
        check("post_rst_frames", frames_sent, 1);

        // 8-bit word width
        in_valid8 = 1'b1; in_tag8 = 8'h10; in_data8 = 8'hF0; #1;
        step();
        in_valid8 = 1'b0; #1;
        for (int i = 0; i < 4; i++) begin
            check("w8_wr_en", fifo_wr_en8, 1);
            check("w8_byte", fifo_wr_data8, exp_w8[i]);
            step(); #1;
        end
        check("w8_busy_end", busy8, 0);
        check("w8_frames", frames_sent8, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
